// File: rtl/key_loader.sv
// rtl/key_loader.sv - serial activation-key receiver with nibble-XOR check and key bus drive
//
// Purpose: accepts a KEY_W+4 bit frame (key bits then 4 check bits, MSB first)
// from the provisioning pin pair, verifies check == XOR of all key nibbles and,
// on success, drives the key onto key_out for the locked datapath modules.
// Until a verified key is present key_out stays all-zero.
//
// Optional feature: define LOCKOUT_EN to enter a LOCKED state once fail_cnt
// reaches MAX_FAIL; only rst leaves LOCKED.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-low reset
//   kin_valid  in   1      serial key bit valid
//   kin_bit    in   1      serial key bit, MSB first
//   kin_ready  out  1      a bit is accepted this cycle when kin_valid is also high
//   clear      in   1      drop the key and return to IDLE (ignored when LOCKED)
//   key_out    out  KEY_W  key bus to the lock modules
//   key_valid  out  1      key_out holds a verified key
//   key_err    out  1      one-cycle pulse on checksum mismatch or timeout
//   busy       out  1      frame in progress (SHIFT or CHECK)
//   fail_cnt   out  4      failed-frame count, saturating at 15
module key_loader #(
  parameter int KEY_W    = 8,
  parameter int MAX_FAIL = 3,
  parameter int TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kin_valid,
  input  logic             kin_bit,
  output logic             kin_ready,
  input  logic             clear,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             key_err,
  output logic             busy,
  output logic [3:0]       fail_cnt
);

  localparam int FRAME_W = KEY_W + 4;
  localparam int BC_W    = $clog2(FRAME_W + 1);
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK,
    S_LOADED
`ifdef LOCKOUT_EN
    , S_LOCKED
`endif
  } state_t;

  state_t             r_state;
  logic [FRAME_W-1:0] r_shift;
  logic [BC_W-1:0]    r_bit_cnt;
  logic [TO_W-1:0]    r_to_cnt;

  logic               w_accept;
  logic               w_clear;
  logic [3:0]         w_calc;
  logic               w_match;
  logic [3:0]         w_fail_inc;
  state_t             w_fail_state;

  // Ready is decoded from the registered state; forced low while rst is held.
  assign kin_ready = rst && ((r_state == S_IDLE) || (r_state == S_SHIFT) ||
                             (r_state == S_LOADED));
  assign busy      = (r_state == S_SHIFT) || (r_state == S_CHECK);
  assign w_accept  = kin_valid && kin_ready;

`ifdef LOCKOUT_EN
  assign w_clear      = clear && (r_state != S_LOCKED);
  assign w_fail_state = (w_fail_inc == 4'(MAX_FAIL)) ? S_LOCKED : S_IDLE;
`else
  assign w_clear      = clear;
  assign w_fail_state = S_IDLE;
`endif

  assign w_fail_inc = (fail_cnt == 4'hF) ? fail_cnt : fail_cnt + 4'd1;

  // Check nibble = XOR of every key nibble; key sits above the 4 check bits.
  always_comb begin
    w_calc = '0;
    for (int i = 0; i < KEY_W / 4; i++) begin
      w_calc = w_calc ^ r_shift[4 + 4*i +: 4];
    end
  end
  assign w_match = (w_calc == r_shift[3:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      fail_cnt  <= 4'd0;
    end else begin
      key_err <= 1'b0;
      if (w_clear) begin
        // clear outranks a same-cycle bit or CHECK verdict
        r_state   <= S_IDLE;
        r_shift   <= '0;
        r_bit_cnt <= '0;
        r_to_cnt  <= '0;
        key_out   <= '0;
        key_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_LOADED: begin
            // LOADED keeps key_out/key_valid until the new frame is judged
            if (w_accept) begin
              r_shift   <= {{(FRAME_W-1){1'b0}}, kin_bit};
              r_bit_cnt <= BC_W'(1);
              r_to_cnt  <= '0;
              r_state   <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            if (w_accept) begin
              r_shift   <= {r_shift[FRAME_W-2:0], kin_bit};
              r_bit_cnt <= r_bit_cnt + BC_W'(1);
              r_to_cnt  <= '0;
              if (r_bit_cnt == BC_W'(FRAME_W - 1)) begin
                r_state <= S_CHECK;
              end
            end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
              // TIMEOUT idle cycles: abort exactly like a checksum failure
              r_state   <= w_fail_state;
              r_shift   <= '0;
              r_bit_cnt <= '0;
              r_to_cnt  <= '0;
              key_out   <= '0;
              key_valid <= 1'b0;
              key_err   <= 1'b1;
              fail_cnt  <= w_fail_inc;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end
          S_CHECK: begin
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            if (w_match) begin
              key_out   <= r_shift[FRAME_W-1:4];
              key_valid <= 1'b1;
              r_state   <= S_LOADED;
            end else begin
              r_state   <= w_fail_state;
              r_shift   <= '0;
              key_out   <= '0;
              key_valid <= 1'b0;
              key_err   <= 1'b1;
              fail_cnt  <= w_fail_inc;
            end
          end
`ifdef LOCKOUT_EN
          S_LOCKED: begin
            key_out   <= '0;
            key_valid <= 1'b0;
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// tb/tb_key_loader.sv - directed self-checking bench for key_loader
module tb_key_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       kin_valid;
  logic       kin_bit;
  logic       kin_ready;
  logic       clear;
  logic [7:0] key_out;
  logic       key_valid;
  logic       key_err;
  logic       busy;
  logic [3:0] fail_cnt;

  int n_cmp = 0;
  int n_err = 0;

  key_loader #(.KEY_W(8), .MAX_FAIL(3), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .kin_valid (kin_valid),
    .kin_bit   (kin_bit),
    .kin_ready (kin_ready),
    .clear     (clear),
    .key_out   (key_out),
    .key_valid (key_valid),
    .key_err   (key_err),
    .busy      (busy),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive frame bits first..last (index 0 = MSB), back-to-back, valid dropped after.
  task automatic send_range(input logic [11:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      kin_valid = 1'b1;
      kin_bit   = f[11-i];
      tick(1);
    end
    kin_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [11:0] f);
    send_range(f, 0, 11);
  endtask

  initial begin
    rst = 1'b0; kin_valid = 1'b0; kin_bit = 1'b0; clear = 1'b0;
    tick(1);
    chk("rst_key_out", 32'(key_out), 32'h0);
    chk("rst_key_valid", 32'(key_valid), 32'h0);
    chk("rst_key_err", 32'(key_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_fail_cnt", 32'(fail_cnt), 32'h0);
    chk("rst_kin_ready", 32'(kin_ready), 32'h0);
    rst = 1'b1;
    tick(1);
    chk("idle_kin_ready", 32'(kin_ready), 32'h1);

    // good frame 0x0F / check 0xF
    send_frame(12'h0FF);
    chk("t1_check_busy", 32'(busy), 32'h1);
    chk("t1_check_ready", 32'(kin_ready), 32'h0);
    chk("t1_check_valid", 32'(key_valid), 32'h0);
    chk("t1_check_err", 32'(key_err), 32'h0);
    tick(1);
    chk("t1_key_out", 32'(key_out), 32'h0F);
    chk("t1_key_valid", 32'(key_valid), 32'h1);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_err", 32'(key_err), 32'h0);

    // reload with 0xA5 / check 0xF: old key held through CHECK
    send_frame(12'hA5F);
    chk("t4_hold_key", 32'(key_out), 32'h0F);
    chk("t4_hold_valid", 32'(key_valid), 32'h1);
    tick(1);
    chk("t4_new_key", 32'(key_out), 32'hA5);

    // bad check 0x0F / 0xE
    send_frame(12'h0FE);
    tick(1);
    chk("t2_key_out", 32'(key_out), 32'h0);
    chk("t2_key_valid", 32'(key_valid), 32'h0);
    chk("t2_err", 32'(key_err), 32'h1);
    chk("t2_fail_cnt", 32'(fail_cnt), 32'h1);
    chk("t2_busy", 32'(busy), 32'h0);
    tick(1);
    chk("t2_err_pulse", 32'(key_err), 32'h0);

    // timeout: 5 bits, then 4 idle cycles
    send_range(12'h3CF, 0, 4);
    tick(3);
    chk("t3_idle3_busy", 32'(busy), 32'h1);
    chk("t3_idle3_err", 32'(key_err), 32'h0);
    tick(1);
    chk("t3_to_err", 32'(key_err), 32'h1);
    chk("t3_to_busy", 32'(busy), 32'h0);
    chk("t3_to_fail", 32'(fail_cnt), 32'h2);
    tick(1);
    chk("t3_to_err_pulse", 32'(key_err), 32'h0);

    // 3 idle cycles then resume: frame 0x3C / 0xF completes
    send_range(12'h3CF, 0, 4);
    tick(3);
    send_range(12'h3CF, 5, 11);
    tick(1);
    chk("t3_resume_key", 32'(key_out), 32'h3C);
    chk("t3_resume_valid", 32'(key_valid), 32'h1);
    chk("t3_resume_fail", 32'(fail_cnt), 32'h2);

    // clear on the 12th bit of a good frame
    send_range(12'h5AF, 0, 10);
    kin_valid = 1'b1; kin_bit = 1'b1; clear = 1'b1;
    tick(1);
    kin_valid = 1'b0; clear = 1'b0;
    chk("t5_clr_busy", 32'(busy), 32'h0);
    chk("t5_clr_key", 32'(key_out), 32'h0);
    chk("t5_clr_valid", 32'(key_valid), 32'h0);
    chk("t5_clr_err", 32'(key_err), 32'h0);
    tick(1);
    chk("t5_clr_err2", 32'(key_err), 32'h0);
    chk("t5_clr_fail", 32'(fail_cnt), 32'h2);
    chk("t5_clr_valid2", 32'(key_valid), 32'h0);

    // load 0x5A, then reset mid-frame
    send_frame(12'h5AF);
    tick(1);
    chk("t5_load_key", 32'(key_out), 32'h5A);
    send_range(12'h0FF, 0, 5);
    rst = 1'b0;
    #1;
    chk("t5_rst_key", 32'(key_out), 32'h0);
    chk("t5_rst_valid", 32'(key_valid), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_fail", 32'(fail_cnt), 32'h0);
    chk("t5_rst_ready", 32'(kin_ready), 32'h0);
    tick(1);
    chk("t5_rst_err", 32'(key_err), 32'h0);
    rst = 1'b1;
    tick(1);

`ifdef LOCKOUT_EN
    for (int i = 0; i < 3; i++) begin
      send_frame(12'h0FE);
      tick(1);
    end
    chk("t6_lock_fail", 32'(fail_cnt), 32'h3);
    chk("t6_lock_ready", 32'(kin_ready), 32'h0);
    send_frame(12'h0FF);
    tick(2);
    chk("t6_lock_valid", 32'(key_valid), 32'h0);
    chk("t6_lock_key", 32'(key_out), 32'h0);
    chk("t6_lock_busy", 32'(busy), 32'h0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(1);
    chk("t6_lock_clear", 32'(kin_ready), 32'h0);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("t6_unlock_ready", 32'(kin_ready), 32'h1);
    chk("t6_unlock_fail", 32'(fail_cnt), 32'h0);
`else
    for (int i = 0; i < 15; i++) begin
      send_frame(12'h0FE);
      tick(1);
    end
    chk("t6_fail15", 32'(fail_cnt), 32'hF);
    send_frame(12'h0FE);
    tick(1);
    chk("t6_sat_fail", 32'(fail_cnt), 32'hF);
    chk("t6_sat_err", 32'(key_err), 32'h1);
    send_frame(12'hA5F);
    tick(1);
    chk("t6_retry_key", 32'(key_out), 32'hA5);
    chk("t6_retry_valid", 32'(key_valid), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
